// File: rtl/rgmii_link_ctrl.sv
// RGMII link-status controller: debounces in-band status and sequences PHY reset on speed change.
// Optional macro RGMII_LINK_CTRL_FORCE_EN adds a management speed override (cfg_force/cfg_force_speed).
module rgmii_link_ctrl #(
    parameter int unsigned STABLE_COUNT  = 16,
    parameter int unsigned RESET_HOLD    = 32,
    parameter int unsigned SETTLE        = 64,
    parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] gmii_rxd,
    input  logic       gmii_rx_dv,
    input  logic       gmii_rx_er,
`ifdef RGMII_LINK_CTRL_FORCE_EN
    input  logic       cfg_force,
    input  logic [1:0] cfg_force_speed,
`endif
    output logic [1:0] speed,
    output logic       link_up,
    output logic       full_duplex,
    output logic       phy_if_rst,
    output logic       busy,
    output logic       status_change
);

    localparam int unsigned MATCH_W = 8;
    localparam int unsigned SEQ_W   = 16;
    localparam logic [MATCH_W-1:0] MATCH_MAX   = '1;
    localparam logic [MATCH_W-1:0] STABLE_LAST = MATCH_W'(STABLE_COUNT - 1);
    localparam logic [SEQ_W-1:0]   HOLD_LAST   = SEQ_W'(RESET_HOLD - 1);
    localparam logic [SEQ_W-1:0]   SETTLE_LAST = SEQ_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_HOLD   = 2'd0,
        S_APPLY  = 2'd1,
        S_SETTLE = 2'd2,
        S_IDLE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [SEQ_W-1:0]   seq_cnt_q, seq_cnt_d;
    logic [1:0]         target_q, target_d;
    logic [1:0]         speed_q, speed_d;
    logic [1:0]         acc_speed_q, acc_speed_d;
    logic [3:0]         cand_q, cand_d;
    logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic               link_up_q, link_up_d;
    logic               full_duplex_q, full_duplex_d;
    logic               phy_if_rst_q, phy_if_rst_d;
    logic               busy_q, busy_d;
    logic               chg_q, chg_d;
    logic               status_change_q, status_change_d;

    logic       sample_valid_c;
    logic       accept_c;
    logic       accept_up_c;
    logic [1:0] want_speed_c;
    logic       unused_rxd_hi;

    assign unused_rxd_hi = ^gmii_rxd[7:4];

    // Debounce: candidate + saturating match counter, updated only on valid idle samples.
    always_comb begin
        cand_d         = cand_q;
        match_cnt_d    = match_cnt_q;
        accept_c       = 1'b0;
        sample_valid_c = !gmii_rx_dv && !gmii_rx_er && (gmii_rxd[2:1] != 2'b11);
        if (sample_valid_c) begin
            if (gmii_rxd[3:0] == cand_q) begin
                accept_c = (match_cnt_q == STABLE_LAST);
                if (match_cnt_q != MATCH_MAX) begin
                    match_cnt_d = match_cnt_q + 8'd1;
                end
            end else begin
                cand_d      = gmii_rxd[3:0];
                match_cnt_d = 8'd1;
            end
        end
    end

    // Speed the sequencer should converge to; a link-down status never moves it.
    always_comb begin
        accept_up_c  = accept_c && cand_q[0];
        acc_speed_d  = accept_up_c ? cand_q[2:1] : acc_speed_q;
`ifdef RGMII_LINK_CTRL_FORCE_EN
        want_speed_c = (cfg_force && (cfg_force_speed != 2'b11)) ? cfg_force_speed : acc_speed_d;
`else
        want_speed_c = acc_speed_d;
`endif
    end

    // Reconfiguration sequencer and registered outputs.
    always_comb begin
        state_d         = state_q;
        seq_cnt_d       = seq_cnt_q;
        target_d        = target_q;
        speed_d         = speed_q;
        link_up_d       = link_up_q;
        full_duplex_d   = full_duplex_q;
        if (accept_c) begin
            link_up_d     = cand_q[0];
            full_duplex_d = cand_q[3];
        end
        case (state_q)
            S_HOLD: begin
                if (seq_cnt_q == HOLD_LAST) begin
                    state_d   = S_APPLY;
                    seq_cnt_d = '0;
                end else begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                end
            end
            S_APPLY: begin
                speed_d   = target_q;
                state_d   = S_SETTLE;
                seq_cnt_d = '0;
            end
            S_SETTLE: begin
                if (seq_cnt_q == SETTLE_LAST) begin
                    seq_cnt_d = '0;
                    if (want_speed_c != speed_q) begin
                        state_d  = S_HOLD;
                        target_d = want_speed_c;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    seq_cnt_d = seq_cnt_q + 16'd1;
                end
            end
            S_IDLE: begin
                if (want_speed_c != speed_q) begin
                    state_d   = S_HOLD;
                    target_d  = want_speed_c;
                    seq_cnt_d = '0;
                end
            end
            default: begin
                state_d   = S_HOLD;
                seq_cnt_d = '0;
            end
        endcase
        phy_if_rst_d    = (state_d == S_HOLD) || (state_d == S_APPLY);
        busy_d          = (state_d != S_IDLE);
        chg_d           = (speed_d != speed_q) || (link_up_d != link_up_q) ||
                          (full_duplex_d != full_duplex_q);
        status_change_d = chg_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_HOLD;
            seq_cnt_q       <= '0;
            target_q        <= DEFAULT_SPEED;
            speed_q         <= DEFAULT_SPEED;
            acc_speed_q     <= DEFAULT_SPEED;
            cand_q          <= '0;
            match_cnt_q     <= '0;
            link_up_q       <= 1'b0;
            full_duplex_q   <= 1'b0;
            phy_if_rst_q    <= 1'b1;
            busy_q          <= 1'b1;
            chg_q           <= 1'b0;
            status_change_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            seq_cnt_q       <= seq_cnt_d;
            target_q        <= target_d;
            speed_q         <= speed_d;
            acc_speed_q     <= acc_speed_d;
            cand_q          <= cand_d;
            match_cnt_q     <= match_cnt_d;
            link_up_q       <= link_up_d;
            full_duplex_q   <= full_duplex_d;
            phy_if_rst_q    <= phy_if_rst_d;
            busy_q          <= busy_d;
            chg_q           <= chg_d;
            status_change_q <= status_change_d;
        end
    end

    assign speed         = speed_q;
    assign link_up       = link_up_q;
    assign full_duplex   = full_duplex_q;
    assign phy_if_rst    = phy_if_rst_q;
    assign busy          = busy_q;
    assign status_change = status_change_q;

endmodule

// File: tb/tb_rgmii_link_ctrl.sv
// Directed self-checking bench for rgmii_link_ctrl (default parameters).
// Exercises the force path too when RGMII_LINK_CTRL_FORCE_EN is defined.
module tb_rgmii_link_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
`ifdef RGMII_LINK_CTRL_FORCE_EN
    logic       cfg_force;
    logic [1:0] cfg_force_speed;
`endif
    logic [1:0] speed;
    logic       link_up;
    logic       full_duplex;
    logic       phy_if_rst;
    logic       busy;
    logic       status_change;

    int checks   = 0;
    int failures = 0;
    int sc_cnt   = 0;
    int sc_base;
    int cyc;
    int cyc2;

    rgmii_link_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .gmii_rxd      (gmii_rxd),
        .gmii_rx_dv    (gmii_rx_dv),
        .gmii_rx_er    (gmii_rx_er),
`ifdef RGMII_LINK_CTRL_FORCE_EN
        .cfg_force     (cfg_force),
        .cfg_force_speed(cfg_force_speed),
`endif
        .speed         (speed),
        .link_up       (link_up),
        .full_duplex   (full_duplex),
        .phy_if_rst    (phy_if_rst),
        .busy          (busy),
        .status_change (status_change)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (status_change === 1'b1) sc_cnt <= sc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic dv, input logic er);
        gmii_rxd   = {4'h0, v};
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic send(input logic [3:0] v, input int n);
        drive(v, 1'b0, 1'b0);
        repeat (n) step();
    endtask

    task automatic wait_rst(input logic val, input int max, output int n);
        n = 0;
        while (phy_if_rst !== val && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic wait_busy(input logic val, input int max, output int n);
        n = 0;
        while (busy !== val && n < max) begin
            step();
            n++;
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(4'h0, 1'b0, 1'b0);
`ifdef RGMII_LINK_CTRL_FORCE_EN
        cfg_force       = 1'b0;
        cfg_force_speed = 2'b00;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_speed", 32'(speed), 32'd2);
        chk("rst_link_up", 32'(link_up), 32'd0);
        chk("rst_phy_if_rst", 32'(phy_if_rst), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_status_change", 32'(status_change), 32'd0);

        // Power-up sequence with idle bus.
        sc_base = sc_cnt;
        rst = 1'b0;
        wait_rst(1'b0, 200, cyc);
        chk("boot_hold_cycles", 32'(cyc), 32'd33);
        wait_busy(1'b0, 200, cyc2);
        chk("boot_busy_fall_cycle", 32'(cyc + cyc2), 32'd97);
        chk("boot_speed", 32'(speed), 32'd2);
        chk("boot_link_up", 32'(link_up), 32'd0);
        chk("boot_no_status_change", 32'(sc_cnt - sc_base), 32'd0);

        // Link up at 100M full duplex.
        sc_base = sc_cnt;
        send(4'hB, 15);
        chk("up100_pre_link", 32'(link_up), 32'd0);
        send(4'hB, 1);
        chk("up100_link_up", 32'(link_up), 32'd1);
        chk("up100_full_duplex", 32'(full_duplex), 32'd1);
        chk("up100_phy_rst_rise", 32'(phy_if_rst), 32'd1);
        chk("up100_speed_held", 32'(speed), 32'd2);
        chk("up100_sc_n1", 32'(status_change), 32'd0);
        step();
        chk("up100_sc_n2", 32'(status_change), 32'd1);
        wait_rst(1'b0, 200, cyc);
        chk("up100_rst_fall_delay", 32'(cyc), 32'd32);
        chk("up100_speed", 32'(speed), 32'd1);
        wait_busy(1'b0, 200, cyc);
        chk("up100_settle_cycles", 32'(cyc), 32'd64);
        repeat (3) step();
        chk("up100_sc_pulses", 32'(sc_cnt - sc_base), 32'd2);

        // Debounce: a single glitch restarts the match count.
        send(4'h0, 16);
        chk("down_link_up", 32'(link_up), 32'd0);
        chk("down_no_sequence", 32'(busy), 32'd0);
        send(4'hB, 15);
        send(4'h5, 1);
        send(4'hB, 15);
        chk("deb_no_accept", 32'(link_up), 32'd0);
        send(4'hB, 1);
        chk("deb_accept", 32'(link_up), 32'd1);
        chk("deb_speed", 32'(speed), 32'd1);
        chk("deb_busy", 32'(busy), 32'd0);

        // Non-idle and reserved-speed cycles do not disturb the count.
        send(4'h0, 16);
        chk("ni_down", 32'(link_up), 32'd0);
        for (int i = 0; i < 15; i++) begin
            drive(4'hB, 1'b0, 1'b0); step();
            drive(4'hB, 1'b1, 1'b0); step();
            drive(4'h6, 1'b0, 1'b0); step();
            drive(4'h0, 1'b0, 1'b1); step();
        end
        chk("ni_no_accept", 32'(link_up), 32'd0);
        send(4'hB, 1);
        chk("ni_accept", 32'(link_up), 32'd1);

`ifdef RGMII_LINK_CTRL_FORCE_EN
        // Forced 10M while in-band reports 1G.
        cfg_force       = 1'b1;
        cfg_force_speed = 2'b00;
        drive(4'h5, 1'b0, 1'b0);
        step();
        chk("force_rst_rise", 32'(phy_if_rst), 32'd1);
        wait_rst(1'b0, 200, cyc);
        chk("force_hold", 32'(cyc), 32'd33);
        chk("force_speed", 32'(speed), 32'd0);
        wait_busy(1'b0, 200, cyc);
        chk("force_settle", 32'(cyc), 32'd64);
        repeat (10) step();
        chk("force_single_seq", 32'(busy), 32'd0);
        chk("force_speed_kept", 32'(speed), 32'd0);
        chk("force_link_inband", 32'(link_up), 32'd1);
        chk("force_duplex_inband", 32'(full_duplex), 32'd0);
        cfg_force = 1'b0;
        step();
        chk("unforce_rst_rise", 32'(phy_if_rst), 32'd1);
`else
        send(4'h5, 16);
        chk("g1_rst_rise", 32'(phy_if_rst), 32'd1);
`endif
        wait_rst(1'b0, 200, cyc);
        chk("g1_hold", 32'(cyc), 32'd33);
        chk("g1_speed", 32'(speed), 32'd2);
        wait_busy(1'b0, 200, cyc);
        chk("g1_settle", 32'(cyc), 32'd64);

        // 1G -> 100M, then 10M accepted during SETTLE.
        send(4'h3, 16);
        chk("cs_rst_rise", 32'(phy_if_rst), 32'd1);
        wait_rst(1'b0, 200, cyc);
        chk("cs_hold", 32'(cyc), 32'd33);
        chk("cs_speed_100", 32'(speed), 32'd1);
        send(4'h1, 16);
        chk("cs_link_up", 32'(link_up), 32'd1);
        chk("cs_duplex", 32'(full_duplex), 32'd0);
        chk("cs_busy_settle", 32'(busy), 32'd1);
        wait_rst(1'b1, 200, cyc);
        chk("cs_rehold_delay", 32'(cyc), 32'd48);
        chk("cs_busy_kept", 32'(busy), 32'd1);
        wait_rst(1'b0, 200, cyc);
        chk("cs_hold2", 32'(cyc), 32'd33);
        chk("cs_speed_10", 32'(speed), 32'd0);
        wait_busy(1'b0, 200, cyc);
        chk("cs_settle2", 32'(cyc), 32'd64);

        // Asynchronous reset during HOLD.
        send(4'hD, 16);
        step();
        chk("ar_sc_pulse", 32'(status_change), 32'd1);
        chk("ar_pre_duplex", 32'(full_duplex), 32'd1);
        chk("ar_pre_speed", 32'(speed), 32'd0);
        rst = 1'b1;
        #1;
        chk("ar_speed", 32'(speed), 32'd2);
        chk("ar_link_up", 32'(link_up), 32'd0);
        chk("ar_full_duplex", 32'(full_duplex), 32'd0);
        chk("ar_phy_if_rst", 32'(phy_if_rst), 32'd1);
        chk("ar_busy", 32'(busy), 32'd1);
        chk("ar_status_change", 32'(status_change), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        chk("ar_release_hold", 32'(phy_if_rst), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgmii_link_ctrl.md
# rgmii_link_ctrl

Link-status controller for the RGMII PHY interface. It decodes RGMII in-band status from the receive GMII stream during inter-frame gaps and debounces it. On a speed change it runs a reset/reconfigure sequence: hold the PHY interface and MAC in reset, switch the `speed` selection, release, then settle. It sits between `rgmii_phy_if`'s receive outputs and that interface's `rst` and `speed` inputs, and reports link status to management logic.

## Interface
- `STABLE_COUNT`, 16: consecutive identical valid status samples required to accept a status (2..255).
- `RESET_HOLD`, 32: cycles `phy_if_rst` is held before the speed switch (1..65535).
- `SETTLE`, 64: cycles after reset release before new changes are acted on (1..65535).
- `DEFAULT_SPEED`, 2'b10: speed applied after reset (2'b10 1G, 2'b01 100M, 2'b00 10M).

Ports:
- `clk` input 1: single clock. Receive GMII signals arrive synchronous to it; cross-domain handling is external.
- `rst` input 1: asynchronous, active-high reset.
- `gmii_rxd` input 8: receive data. Only [3:0] is decoded.
- `gmii_rx_dv` input 1: receive data valid.
- `gmii_rx_er` input 1: receive error.
- `speed` output 2: speed select to the PHY interface.
- `link_up` output 1: debounced link status.
- `full_duplex` output 1: debounced duplex status.
- `phy_if_rst` output 1: reset to the PHY interface/MAC, active-high.
- `busy` output 1: a reconfiguration sequence is in progress.
- `status_change` output 1: one-cycle pulse when `speed`, `link_up` or `full_duplex` changes.

## Operation
- **Valid sample:** a cycle with `gmii_rx_dv`=0, `gmii_rx_er`=0 and `gmii_rxd[2:1]`≠2'b11. Decoded fields:
  - `gmii_rxd[0]` = link
  - `gmii_rxd[2:1]` = speed
  - `gmii_rxd[3]` = duplex
- **Debounce:**
  - A 4-bit candidate register plus an 8-bit saturating match counter.
  - A valid sample equal to the candidate increments the counter.
  - A valid sample that differs from the candidate loads the candidate and sets the counter to 1.
  - Invalid or non-idle cycles hold both registers.
- **Acceptance:** occurs on the edge where the counter reaches `STABLE_COUNT`. The counter then saturates, so acceptance is re-armed only by a candidate change. On acceptance:
  - `link_up` and `full_duplex` load from the candidate on that edge.
  - If candidate speed ≠ `speed` and the state is IDLE, the target latches the candidate speed and the state enters HOLD.
- FSM states:
  - HOLD: `phy_if_rst`=1, `busy`=1; counts `RESET_HOLD` cycles, then APPLY.
  - APPLY: one cycle; `speed`←target; `phy_if_rst`←0 on exit; next state SETTLE.
  - SETTLE: `busy`=1; counts `SETTLE` cycles, then IDLE.
  - IDLE: `busy`=0.
- **Acceptance while not IDLE:** link and duplex still update. A speed mismatch is rechecked on entry to IDLE: if the last accepted speed ≠ `speed`, the FSM goes directly back to HOLD.
- **Link down:** does not change `speed` and does not trigger a sequence.

## Timing
- Reset values:
  - state = HOLD
  - target = `DEFAULT_SPEED`
  - `speed` = `DEFAULT_SPEED`
  - `link_up` = 0, `full_duplex` = 0
  - `phy_if_rst` = 1, `busy` = 1, `status_change` = 0
  - candidate = 0, counter = 0
- After `rst` deasserts, the full HOLD→APPLY→SETTLE sequence runs once before IDLE.
- All outputs are registered.
- Latency, with sample n being the `STABLE_COUNT`-th match:
  - `link_up`/`full_duplex` are valid in cycle n+1.
  - `phy_if_rst` rises in cycle n+1.
  - `speed` changes and `phy_if_rst` falls in cycle n+`RESET_HOLD`+2.
  - `busy` falls in cycle n+`RESET_HOLD`+`SETTLE`+2.
- `status_change` is asserted in the cycle after any of its three outputs changes.
- `rst` mid-sequence returns to the reset values immediately (asynchronously).

## Configuration
- `RGMII_LINK_CTRL_FORCE_EN` defined:
  - Adds inputs `cfg_force` (1 bit) and `cfg_force_speed` (2 bits).
  - While `cfg_force`=1 and `cfg_force_speed`≠2'b11, the speed mismatch check uses `cfg_force_speed` instead of the accepted in-band speed. Comparison happens every IDLE cycle, with no debounce.
  - `link_up`/`full_duplex` remain in-band driven.
- Not defined: these ports are absent, and speed follows in-band status only.

## Test plan
- **Reset release, defaults:** release `rst`, no stimulus → `phy_if_rst`=1 for 33 cycles, `busy`=0 at cycle 97, `speed`=2'b10, `link_up`=0.
- **Link up at 100M:** 16 idle samples with `gmii_rxd[3:0]`=4'hB → `link_up`=1, `full_duplex`=1; `phy_if_rst` high 33 cycles; `speed`=2'b01; one `status_change` pulse per output change.
- **Debounce:** 15 samples of 4'hB, one 4'h5, 15 of 4'hB → no acceptance; a 16th consecutive 4'hB then accepts.
- **Non-idle cycles:** samples interleaved with `gmii_rx_dv`=1 cycles and `gmii_rxd[2:1]`=2'b11 samples → counter holds; acceptance after exactly 16 valid matching samples.
- **Change during SETTLE:** accept 4'h3 (1G→100M path), then accept 4'h1 (10M) during SETTLE → second sequence starts on IDLE entry; final `speed`=2'b00.
- **Force path:** with `RGMII_LINK_CTRL_FORCE_EN` defined, `cfg_force`=1, `cfg_force_speed`=2'b00, in-band 1G → `speed`=2'b00 after one sequence. `rst` asserted mid-HOLD → outputs return to reset values.
